// File: rtl/emesh_pkg.sv
// rtl/emesh_pkg.sv - shared emesh transaction widths and burst constants
package emesh_pkg;

   localparam int DM_W = 2;
   localparam int CM_W = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int GW   = 2;

   localparam logic [DM_W-1:0] DATAMODE_DOUBLE = 2'b11;
   localparam logic [AW-1:0]   BURST_STRIDE    = 32'd8;

   // A double-word write is the only transaction type that can chain into a burst
   function automatic logic is_double_write(input logic write, input logic [DM_W-1:0] datamode);
      return write & (datamode == DATAMODE_DOUBLE);
   endfunction

endpackage

// File: rtl/emesh_rr_pick.sv
// rtl/emesh_rr_pick.sv - round-robin priority picker: request vector + pointer to one-hot winner and index
module emesh_rr_pick
   import emesh_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [GW-1:0]   idx,
   output logic            valid
);

   int pos;

   // Scan upward from the pointer, wrapping at NREQ; the first set request wins
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      pos   = 0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (int'(ptr) + k) % NREQ;
         if (!valid && req[pos]) begin
            valid      = 1'b1;
            grant[pos] = 1'b1;
            idx        = GW'(pos);
         end
      end
   end

endmodule

// File: rtl/emesh_tx_arbiter.sv
// rtl/emesh_tx_arbiter.sv - round-robin emesh transmit arbiter with single output stage and burst grant locking
module emesh_tx_arbiter
   import emesh_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int MAX_BURST = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 burst_en,
   input  logic [NREQ-1:0]      req_access,
   input  logic [NREQ-1:0]      req_write,
   input  logic [DM_W*NREQ-1:0] req_datamode,
   input  logic [CM_W*NREQ-1:0] req_ctrlmode,
   input  logic [AW*NREQ-1:0]   req_dstaddr,
   input  logic [AW*NREQ-1:0]   req_srcaddr,
   input  logic [DW*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_wr_wait,
   output logic [NREQ-1:0]      req_rd_wait,
   output logic                 emesh_access_outb,
   output logic                 emesh_write_outb,
   output logic [DM_W-1:0]      emesh_datamode_outb,
   output logic [CM_W-1:0]      emesh_ctrlmode_outb,
   output logic [AW-1:0]        emesh_dstaddr_outb,
   output logic [AW-1:0]        emesh_srcaddr_outb,
   output logic [DW-1:0]        emesh_data_outb,
   input  logic                 emesh_wr_wait_inb,
   input  logic                 emesh_rd_wait_inb,
   output logic [GW-1:0]        grant_id,
   output logic                 burst_active
);

   localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_BURST - 1);

   logic [GW-1:0]   rr_ptr;
   logic [CW-1:0]   beat_cnt;
   logic [NREQ-1:0] prev_dbl;
   logic [AW-1:0]   prev_addr [NREQ];

   logic            stage_blocked;
   logic            can_load;
   logic [NREQ-1:0] rr_onehot;
   logic [GW-1:0]   rr_idx;
   logic            rr_valid;
   logic            lock_hold;
   logic [NREQ-1:0] lock_onehot;
   logic [NREQ-1:0] win_onehot;
   logic [GW-1:0]   win_idx;
   logic            win_valid;
   logic            accept;
   logic            w_write;
   logic [DM_W-1:0] w_dm;
   logic [CM_W-1:0] w_cm;
   logic [AW-1:0]   w_dst;
   logic [AW-1:0]   w_src;
   logic [DW-1:0]   w_data;
   logic            w_prev_dbl;
   logic [AW-1:0]   w_prev_addr;
   logic            w_dbl;
   logic            chain;
   logic            last_beat;
   logic [GW-1:0]   next_ptr;

   assign stage_blocked = emesh_access_outb & (emesh_write_outb ? emesh_wr_wait_inb : emesh_rd_wait_inb);
   assign can_load      = !emesh_access_outb | !stage_blocked;

   emesh_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_access),
      .ptr   (rr_ptr),
      .grant (rr_onehot),
      .idx   (rr_idx),
      .valid (rr_valid)
   );

   // The locked owner keeps the grant while it still has a request pending
   always_comb begin
      lock_hold   = 1'b0;
      lock_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == GW'(i)) begin
            lock_hold      = burst_active & req_access[i];
            lock_onehot[i] = 1'b1;
         end
      end
   end

   assign win_onehot = lock_hold ? lock_onehot : rr_onehot;
   assign win_idx    = lock_hold ? grant_id : rr_idx;
   assign win_valid  = lock_hold | rr_valid;
   assign accept     = can_load & win_valid;

   // Route the winning requester's fields and its burst history
   always_comb begin
      w_write     = 1'b0;
      w_dm        = '0;
      w_cm        = '0;
      w_dst       = '0;
      w_src       = '0;
      w_data      = '0;
      w_prev_dbl  = 1'b0;
      w_prev_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_onehot[i]) begin
            w_write     = req_write[i];
            w_dm        = req_datamode[i*DM_W +: DM_W];
            w_cm        = req_ctrlmode[i*CM_W +: CM_W];
            w_dst       = req_dstaddr[i*AW +: AW];
            w_src       = req_srcaddr[i*AW +: AW];
            w_data      = req_data[i*DW +: DW];
            w_prev_dbl  = prev_dbl[i];
            w_prev_addr = prev_addr[i];
         end
      end
   end

   assign w_dbl     = is_double_write(w_write, w_dm);
   assign chain     = burst_en & w_dbl & w_prev_dbl & (w_dst == w_prev_addr + BURST_STRIDE) &
                      (beat_cnt < BEAT_LIMIT);
   assign last_beat = ((beat_cnt + 1'b1) == BEAT_LIMIT);
   assign next_ptr  = (win_idx == GW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

   // Only the accepted requester sees its waits drop; everyone is held during reset
   assign req_wr_wait = ~({NREQ{reset_n & accept}} & win_onehot);
   assign req_rd_wait = ~({NREQ{reset_n & accept}} & win_onehot);

   // Output stage load, grant/pointer update and burst lock tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         emesh_access_outb   <= 1'b0;
         emesh_write_outb    <= 1'b0;
         emesh_datamode_outb <= '0;
         emesh_ctrlmode_outb <= '0;
         emesh_dstaddr_outb  <= '0;
         emesh_srcaddr_outb  <= '0;
         emesh_data_outb     <= '0;
         grant_id            <= '0;
         burst_active        <= 1'b0;
         rr_ptr              <= '0;
         beat_cnt            <= '0;
         prev_dbl            <= '0;
         for (int i = 0; i < NREQ; i++) prev_addr[i] <= '0;
      end else begin
         if (can_load) begin
            if (accept) begin
               emesh_access_outb   <= 1'b1;
               emesh_write_outb    <= w_write;
               emesh_datamode_outb <= w_dm;
               emesh_ctrlmode_outb <= w_cm;
               emesh_dstaddr_outb  <= w_dst;
               emesh_srcaddr_outb  <= w_src;
               emesh_data_outb     <= w_data;
               grant_id            <= win_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (win_onehot[i]) begin
                     prev_dbl[i]  <= w_dbl;
                     prev_addr[i] <= w_dst;
                  end
               end
               if (chain && !last_beat) begin
                  burst_active <= 1'b1;
                  beat_cnt     <= beat_cnt + 1'b1;
               end else begin
                  burst_active <= 1'b0;
                  beat_cnt     <= '0;
                  rr_ptr       <= next_ptr;
               end
            end else begin
               emesh_access_outb <= 1'b0;
               burst_active      <= 1'b0;
               beat_cnt          <= '0;
            end
         end
         if (!burst_en) begin
            burst_active <= 1'b0;
            beat_cnt     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_emesh_tx_arbiter.sv
// tb/tb_emesh_tx_arbiter.sv - directed self-checking bench for emesh_tx_arbiter
module tb_emesh_tx_arbiter;

   logic        clk;
   logic        reset_n;
   logic        burst_en;
   logic [1:0]  req_access;
   logic [1:0]  req_write;
   logic [3:0]  req_datamode;
   logic [7:0]  req_ctrlmode;
   logic [63:0] req_dstaddr;
   logic [63:0] req_srcaddr;
   logic [63:0] req_data;
   logic [1:0]  req_wr_wait;
   logic [1:0]  req_rd_wait;
   logic        emesh_access_outb;
   logic        emesh_write_outb;
   logic [1:0]  emesh_datamode_outb;
   logic [3:0]  emesh_ctrlmode_outb;
   logic [31:0] emesh_dstaddr_outb;
   logic [31:0] emesh_srcaddr_outb;
   logic [31:0] emesh_data_outb;
   logic        emesh_wr_wait_inb;
   logic        emesh_rd_wait_inb;
   logic [1:0]  grant_id;
   logic        burst_active;

   int vectors;
   int miscompares;

   emesh_tx_arbiter #(.NREQ(2), .MAX_BURST(16)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .burst_en            (burst_en),
      .req_access          (req_access),
      .req_write           (req_write),
      .req_datamode        (req_datamode),
      .req_ctrlmode        (req_ctrlmode),
      .req_dstaddr         (req_dstaddr),
      .req_srcaddr         (req_srcaddr),
      .req_data            (req_data),
      .req_wr_wait         (req_wr_wait),
      .req_rd_wait         (req_rd_wait),
      .emesh_access_outb   (emesh_access_outb),
      .emesh_write_outb    (emesh_write_outb),
      .emesh_datamode_outb (emesh_datamode_outb),
      .emesh_ctrlmode_outb (emesh_ctrlmode_outb),
      .emesh_dstaddr_outb  (emesh_dstaddr_outb),
      .emesh_srcaddr_outb  (emesh_srcaddr_outb),
      .emesh_data_outb     (emesh_data_outb),
      .emesh_wr_wait_inb   (emesh_wr_wait_inb),
      .emesh_rd_wait_inb   (emesh_rd_wait_inb),
      .grant_id            (grant_id),
      .burst_active        (burst_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic set_req(input int i, input logic acc, input logic wr, input logic [1:0] dm,
                          input logic [31:0] dst, input logic [31:0] dat);
      req_access[i]            = acc;
      req_write[i]             = wr;
      req_datamode[i*2 +: 2]   = dm;
      req_ctrlmode[i*4 +: 4]   = 4'(i + 1);
      req_dstaddr[i*32 +: 32]  = dst;
      req_srcaddr[i*32 +: 32]  = 32'h1000 + 32'(i);
      req_data[i*32 +: 32]     = dat;
   endtask

   task automatic do_reset();
      reset_n           = 1'b0;
      burst_en          = 1'b0;
      emesh_wr_wait_inb = 1'b0;
      emesh_rd_wait_inb = 1'b0;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n           = 1'b0;
      burst_en          = 1'b0;
      emesh_wr_wait_inb = 1'b0;
      emesh_rd_wait_inb = 1'b0;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #2;
      vectors++; if (emesh_access_outb !== 1'b0) begin miscompares++; $display("FAIL reset_access got %0h exp 0", emesh_access_outb); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant got %0h exp 0", grant_id); end
      vectors++; if (burst_active !== 1'b0) begin miscompares++; $display("FAIL reset_burst got %0h exp 0", burst_active); end
      vectors++; if (req_wr_wait !== 2'b11) begin miscompares++; $display("FAIL reset_wr_wait got %b exp 11", req_wr_wait); end
      vectors++; if (req_rd_wait !== 2'b11) begin miscompares++; $display("FAIL reset_rd_wait got %b exp 11", req_rd_wait); end
      vectors++; if (emesh_dstaddr_outb !== 32'h0) begin miscompares++; $display("FAIL reset_dstaddr got %h exp 0", emesh_dstaddr_outb); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      vectors++; if (req_wr_wait !== 2'b11) begin miscompares++; $display("FAIL idle_wr_wait got %b exp 11", req_wr_wait); end
      @(posedge clk); #1;
      vectors++; if (emesh_access_outb !== 1'b0) begin miscompares++; $display("FAIL idle_access got %0h exp 0", emesh_access_outb); end
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'hDEAD_BEEF);
      @(negedge clk);
      vectors++; if (req_wr_wait !== 2'b10) begin miscompares++; $display("FAIL single_wr_wait got %b exp 10", req_wr_wait); end
      vectors++; if (req_rd_wait !== 2'b10) begin miscompares++; $display("FAIL single_rd_wait got %b exp 10", req_rd_wait); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      vectors++; if (emesh_access_outb !== 1'b1) begin miscompares++; $display("FAIL single_access got %0h exp 1", emesh_access_outb); end
      vectors++; if (emesh_write_outb !== 1'b1) begin miscompares++; $display("FAIL single_write got %0h exp 1", emesh_write_outb); end
      vectors++; if (emesh_datamode_outb !== 2'b10) begin miscompares++; $display("FAIL single_datamode got %b exp 10", emesh_datamode_outb); end
      vectors++; if (emesh_ctrlmode_outb !== 4'h1) begin miscompares++; $display("FAIL single_ctrlmode got %h exp 1", emesh_ctrlmode_outb); end
      vectors++; if (emesh_dstaddr_outb !== 32'h8000_0000) begin miscompares++; $display("FAIL single_dstaddr got %h exp 80000000", emesh_dstaddr_outb); end
      vectors++; if (emesh_srcaddr_outb !== 32'h0000_1000) begin miscompares++; $display("FAIL single_srcaddr got %h exp 00001000", emesh_srcaddr_outb); end
      vectors++; if (emesh_data_outb !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data got %h exp deadbeef", emesh_data_outb); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL single_grant got %0d exp 0", grant_id); end
      @(posedge clk); #1;
      vectors++; if (emesh_access_outb !== 1'b0) begin miscompares++; $display("FAIL single_drain got %0h exp 0", emesh_access_outb); end
   endtask

   task automatic test_alternate();
      logic [1:0]  acc;
      logic [1:0]  exp_wait;
      logic [31:0] exp_data;
      int n0;
      int n1;
      do_reset();
      n0 = 0;
      n1 = 0;
      set_req(0, 1'b1, 1'b1, 2'b10, 32'h100, 32'h100);
      set_req(1, 1'b1, 1'b1, 2'b10, 32'h200, 32'h200);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp_wait = (c % 2 == 0) ? 2'b10 : 2'b01;
         vectors++; if (req_wr_wait !== exp_wait) begin miscompares++; $display("FAIL alt_wait[%0d] got %b exp %b", c, req_wr_wait, exp_wait); end
         acc = ~req_wr_wait & req_access;
         @(posedge clk); #1;
         exp_data = ((c % 2 == 0) ? 32'h100 : 32'h200) + 32'(c / 2);
         vectors++; if (emesh_access_outb !== 1'b1) begin miscompares++; $display("FAIL alt_access[%0d] got %0h exp 1", c, emesh_access_outb); end
         vectors++; if (grant_id !== 2'(c % 2)) begin miscompares++; $display("FAIL alt_grant[%0d] got %0d exp %0d", c, grant_id, c % 2); end
         vectors++; if (emesh_data_outb !== exp_data) begin miscompares++; $display("FAIL alt_data[%0d] got %h exp %h", c, emesh_data_outb, exp_data); end
         if (acc[0]) begin n0++; set_req(0, 1'b1, 1'b1, 2'b10, 32'h100, 32'h100 + 32'(n0)); end
         if (acc[1]) begin n1++; set_req(1, 1'b1, 1'b1, 2'b10, 32'h200, 32'h200 + 32'(n1)); end
      end
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
   endtask

   task automatic test_wait_hold();
      do_reset();
      set_req(0, 1'b1, 1'b1, 2'b10, 32'h10, 32'h55);
      @(posedge clk); #1;
      emesh_wr_wait_inb = 1'b1;
      set_req(0, 1'b1, 1'b1, 2'b10, 32'h14, 32'h66);
      set_req(1, 1'b1, 1'b1, 2'b10, 32'h24, 32'h77);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (req_wr_wait !== 2'b11) begin miscompares++; $display("FAIL hold_wait[%0d] got %b exp 11", c, req_wr_wait); end
         @(posedge clk); #1;
         vectors++; if (emesh_data_outb !== 32'h55 || emesh_access_outb !== 1'b1) begin miscompares++; $display("FAIL hold_stage[%0d] got %h/%0h exp 55/1", c, emesh_data_outb, emesh_access_outb); end
      end
      emesh_wr_wait_inb = 1'b0;
      @(negedge clk);
      vectors++; if (req_wr_wait !== 2'b01) begin miscompares++; $display("FAIL release_wait got %b exp 01", req_wr_wait); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL release_grant got %0d exp 1", grant_id); end
      vectors++; if (emesh_data_outb !== 32'h77) begin miscompares++; $display("FAIL release_data got %h exp 77", emesh_data_outb); end
   endtask

   task automatic test_burst();
      logic [1:0]  acc;
      logic [1:0]  exp_grant;
      logic [31:0] exp_data;
      logic        exp_burst;
      int k;
      do_reset();
      burst_en = 1'b1;
      k = 0;
      set_req(0, 1'b1, 1'b1, 2'b11, 32'h0, 32'h0);
      for (int i = 0; i < 21; i++) begin
         if (i == 2) set_req(1, 1'b1, 1'b1, 2'b10, 32'h4000, 32'hB1);
         @(negedge clk);
         acc = ~req_wr_wait & req_access;
         @(posedge clk); #1;
         exp_grant = (i == 16) ? 2'd1 : 2'd0;
         exp_data  = (i < 16) ? 32'(i) : ((i == 16) ? 32'hB1 : 32'(i - 1));
         exp_burst = ((i >= 1) && (i <= 14)) || (i >= 17);
         vectors++; if (grant_id !== exp_grant) begin miscompares++; $display("FAIL burst_grant[%0d] got %0d exp %0d", i, grant_id, exp_grant); end
         vectors++; if (emesh_data_outb !== exp_data) begin miscompares++; $display("FAIL burst_data[%0d] got %h exp %h", i, emesh_data_outb, exp_data); end
         vectors++; if (burst_active !== exp_burst) begin miscompares++; $display("FAIL burst_active[%0d] got %0h exp %0h", i, burst_active, exp_burst); end
         if (acc[0]) begin
            k++;
            if (k < 20) set_req(0, 1'b1, 1'b1, 2'b11, 32'(8 * k), 32'(k));
            else        set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
         end
         if (acc[1]) set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      burst_en = 1'b0;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
   endtask

   task automatic test_burst_gap();
      logic [31:0] gap_addr [3];
      logic [1:0]  exp_grant [4];
      logic        exp_burst [4];
      logic [31:0] exp_data  [4];
      logic [1:0]  acc;
      int k;
      gap_addr  = '{32'h0, 32'h8, 32'h20};
      exp_grant = '{2'd0, 2'd0, 2'd0, 2'd1};
      exp_burst = '{1'b0, 1'b1, 1'b0, 1'b0};
      exp_data  = '{32'hA0, 32'hA1, 32'hA2, 32'hC1};
      do_reset();
      burst_en = 1'b1;
      k = 0;
      set_req(0, 1'b1, 1'b1, 2'b11, gap_addr[0], 32'hA0);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) set_req(1, 1'b1, 1'b1, 2'b10, 32'h5000, 32'hC1);
         @(negedge clk);
         acc = ~req_wr_wait & req_access;
         @(posedge clk); #1;
         vectors++; if (grant_id !== exp_grant[i]) begin miscompares++; $display("FAIL gap_grant[%0d] got %0d exp %0d", i, grant_id, exp_grant[i]); end
         vectors++; if (burst_active !== exp_burst[i]) begin miscompares++; $display("FAIL gap_burst[%0d] got %0h exp %0h", i, burst_active, exp_burst[i]); end
         vectors++; if (emesh_data_outb !== exp_data[i]) begin miscompares++; $display("FAIL gap_data[%0d] got %h exp %h", i, emesh_data_outb, exp_data[i]); end
         if (acc[0]) begin
            k++;
            if (k < 3) set_req(0, 1'b1, 1'b1, 2'b11, gap_addr[k], 32'hA0 + 32'(k));
            else       set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
         end
         if (acc[1]) set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      burst_en = 1'b0;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(1, 1'b1, 1'b1, 2'b10, 32'h30, 32'h99);
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      emesh_wr_wait_inb = 1'b1;
      vectors++; if (grant_id !== 2'd1 || emesh_access_outb !== 1'b1) begin miscompares++; $display("FAIL mid_preload got %0d/%0h exp 1/1", grant_id, emesh_access_outb); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (emesh_access_outb !== 1'b0) begin miscompares++; $display("FAIL mid_access got %0h exp 0", emesh_access_outb); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL mid_grant got %0d exp 0", grant_id); end
      vectors++; if (req_wr_wait !== 2'b11) begin miscompares++; $display("FAIL mid_wait got %b exp 11", req_wr_wait); end
      @(posedge clk); #1;
      emesh_wr_wait_inb = 1'b0;
      reset_n = 1'b1;
      set_req(0, 1'b1, 1'b1, 2'b10, 32'h40, 32'h11);
      set_req(1, 1'b1, 1'b1, 2'b10, 32'h50, 32'h22);
      @(negedge clk);
      vectors++; if (req_wr_wait !== 2'b10) begin miscompares++; $display("FAIL post_reset_wait got %b exp 10", req_wr_wait); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL post_reset_grant got %0d exp 0", grant_id); end
      vectors++; if (emesh_data_outb !== 32'h11) begin miscompares++; $display("FAIL post_reset_data got %h exp 11", emesh_data_outb); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_alternate();
      test_wait_hold();
      test_burst();
      test_burst_gap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/emesh_tx_arbiter.md
Name: emesh_tx_arbiter

Overview:
Round-robin arbiter that shares the single elink transmit path (the emesh "outb" input of the link transmitter) between NREQ emesh masters, e.g. the AXI slave bridge and the register/mailbox master. It registers the winning transaction into one output stage and honours the transmitter's wr_wait/rd_wait back-pressure. It keeps the grant on one requester for sequential double-word write bursts, so the transmitter can emit back-to-back burst frames.

Parameters:
NREQ, 2, number of requesters (2..4)
MAX_BURST, 16, max beats granted to one requester in a locked write burst before a forced rotation

Ports:
clk  in  1  transmit-side emesh clock
reset_n  in  1  asynchronous active-low reset
burst_en  in  1  enables burst grant locking
req_access  in  NREQ  per-requester transaction valid
req_write  in  NREQ  1=write, 0=read
req_datamode  in  2*NREQ  per-requester datamode, requester i at [2i+1:2i]
req_ctrlmode  in  4*NREQ  per-requester ctrlmode
req_dstaddr  in  32*NREQ  per-requester destination address
req_srcaddr  in  32*NREQ  per-requester source address
req_data  in  32*NREQ  per-requester data
req_wr_wait  out  NREQ  hold request i (write)
req_rd_wait  out  NREQ  hold request i (read)
emesh_access_outb  out  1  transaction valid to transmitter
emesh_write_outb  out  1
emesh_datamode_outb  out  2
emesh_ctrlmode_outb  out  4
emesh_dstaddr_outb  out  32
emesh_srcaddr_outb  out  32
emesh_data_outb  out  32
emesh_wr_wait_inb  in  1  transmitter write back-pressure
emesh_rd_wait_inb  in  1  transmitter read back-pressure
grant_id  out  2  index of requester owning the output stage
burst_active  out  1  grant is locked for a burst

Behaviour:
- Reset (reset_n=0, async): emesh_access_outb=0; all other emesh_*_outb=0; grant_id=0; burst_active=0; RR pointer=0; beat counter=0. req_wr_wait and req_rd_wait=all 1 while reset_n=0; they follow the rules below from the first cycle after release.
- Output stage ("stage"): holds one transaction. stage_blocked = emesh_access_outb & (emesh_write_outb ? emesh_wr_wait_inb : emesh_rd_wait_inb).
- A transaction is taken by the transmitter on a clk edge with emesh_access_outb=1 and stage_blocked=0.
- can_load = !emesh_access_outb | !stage_blocked. This is a same-cycle free slot, giving full throughput of 1 transaction/cycle.
- Winner selection (combinational, valid when can_load):
  - If burst_active and req_access[grant_id]: the winner is grant_id.
  - Otherwise, the first requester with req_access=1 searching from the RR pointer upward, modulo NREQ.
- Requester handshake: requester i's transaction is accepted on an edge where can_load=1 and i is the winner. In that cycle req_wr_wait[i]=req_rd_wait[i]=0. All other requesters see both waits =1. A requester holds its fields stable while its wait is 1.
- Load: on accept, copy the winner's fields into the stage and set grant_id=winner. If can_load=1 and no request is present, emesh_access_outb←0.
- Latency: request accepted at edge N → emesh_access_outb=1 after edge N. Minimum 1 cycle.
- RR pointer: on accept without lock, pointer←(winner+1) mod NREQ. Unchanged while the grant is locked.
- Burst lock: set burst_active on accept when all of the following hold:
  - burst_en=1
  - the accepted transaction is a write with datamode=2'b11
  - the same requester's previous accepted transaction was a write with datamode=2'b11
  - dstaddr == previous dstaddr + 8 (32-bit wrap allowed)
  - beat counter < MAX_BURST-1
  Each locked beat increments the beat counter.
- Burst lock clear: clear burst_active and the beat counter on any of:
  - an accept that breaks the address/type rule
  - req_access[grant_id]=0 while can_load=1
  - burst_en=0
  - beat counter reaching MAX_BURST-1
  On a forced clear at MAX_BURST, the pointer←grant_id+1, so any other pending requester wins next.
- Simultaneous events: a stage take and a new load on the same edge is legal, with no bubble. A read request blocked only by rd_wait does not block a different requester's write: it is not accepted only if the stage is occupied.
- burst_en deasserted mid-burst: the lock drops on the next edge; the current stage content is unaffected.
- Reset mid-transaction drops the stage content; no partial transaction is emitted.

Decomposition:
- Shared package emesh_pkg holds:
  - the emesh transaction field widths (datamode 2, ctrlmode 4, addr/data 32)
  - the constant DATAMODE_DOUBLE=2'b11
  - the burst address stride constant 8
- One sub-module, emesh_rr_pick: a parameterised NREQ round-robin priority picker (request vector + pointer → one-hot winner + index).

Test Plan:
- Single requester 0 writes dstaddr 0x80000000, data 0xDEADBEEF, no wait → emesh_access_outb=1 one cycle later with identical fields; grant_id=0; req_wr_wait[0]=0 on the accept cycle.
- Both requesters assert continuous single-word writes → alternating grant_id 0,1,0,1; one transaction per cycle; no bubbles.
- Stage holds a write and emesh_wr_wait_inb=1 for 5 cycles → output fields stable for 5 cycles; both req_wr_wait=1; first new accept on the cycle wait drops.
- burst_en=1; requester 0 issues 20 double writes with dstaddr 0x0, 0x8, 0x10, …; requester 1 pending → 16 consecutive grants to requester 0, then requester 1 wins, then requester 0 resumes.
- Burst with an address gap (0x0, 0x8, 0x20) and requester 1 pending → lock drops at 0x20; requester 1 is granted next.
- reset_n asserted while the stage is occupied and wr_wait=1 → emesh_access_outb=0 immediately (async); grant_id=0; after release, requester 0 is accepted first.
